// File: rtl/dec_pkg.sv
// Shared decoder definitions: mode encodings and a generic one-hot helper.
// The helper is sized for the widest decoder; callers truncate to their own width.
package dec_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam int OH_IDX_W = 8;
   localparam int OH_MAX_W = 1 << OH_IDX_W;

   function automatic logic [OH_MAX_W-1:0] onehot(input logic [OH_IDX_W-1:0] i);
      logic [OH_MAX_W-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/seq_decoder_if.sv
// Control/status bundle for seq_decoder; master drives controls, slave is the decoder.
interface seq_decoder_if #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
);
   logic                    oe;
   logic                    mode;
   logic                    load;
   logic [SEL_W-1:0]        sel;
   logic                    step_en;
   logic [DWELL_W-1:0]      dwell;
   logic [(1<<SEL_W)-1:0]   out;
   logic [SEL_W-1:0]        idx;
   logic                    wrap;

   modport master (
      output oe, mode, load, sel, step_en, dwell,
      input  out, idx, wrap
   );

   modport slave (
      input  oe, mode, load, sel, step_en, dwell,
      output out, idx, wrap
   );
endinterface

// File: rtl/seq_dwell_cnt.sv
// Dwell counter: counts qualified cycles and ticks when the count reaches dwell.
// dwell is compared live, so lowering it below cnt lets cnt roll over before matching.
module seq_dwell_cnt #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               en,
   input  logic [DWELL_W-1:0] dwell,
   output logic               tick
);

   logic [DWELL_W-1:0] cnt;
   logic               hit;

   assign hit  = (cnt == dwell);
   assign tick = en && hit && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= hit ? '0 : cnt + DWELL_W'(1);
      end
   end

endmodule

// File: rtl/seq_decoder.sv
// Registered 1-of-2^SEL_W decoder with output enable and dwell-timed auto-scan.
// out is decoded from the next index so out and idx always agree when oe is high.
module seq_decoder
   import dec_pkg::*;
#(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   seq_decoder_if.slave   bus
);

   localparam int               OUT_W   = 1 << SEL_W;
   localparam logic [SEL_W-1:0] IDX_MAX = '1;

   logic             mode_q;
   logic             scan_entry;
   logic             cnt_clear;
   logic             scan_en;
   logic             tick;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             wrap_q, wrap_d;

   // Direct mode and scan entry both park the counter so each scan starts with a full dwell.
   assign scan_entry = (bus.mode == MODE_SCAN) && (mode_q == MODE_DIRECT);
   assign cnt_clear  = bus.load || scan_entry || (bus.mode == MODE_DIRECT);
   assign scan_en    = (bus.mode == MODE_SCAN) && bus.step_en;

   seq_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (cnt_clear),
      .en    (scan_en),
      .dwell (bus.dwell),
      .tick  (tick)
   );

   always_comb begin
      idx_d  = idx_q;
      wrap_d = 1'b0;
      if (bus.load) begin
         idx_d = bus.sel;
      end else if (tick) begin
         idx_d  = idx_q + SEL_W'(1);
         wrap_d = (idx_q == IDX_MAX);
      end
      out_d = bus.oe ? OUT_W'(onehot(OH_IDX_W'(idx_d))) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         out_q  <= '0;
         wrap_q <= 1'b0;
         mode_q <= MODE_DIRECT;
      end else begin
         idx_q  <= idx_d;
         out_q  <= out_d;
         wrap_q <= wrap_d;
         mode_q <= bus.mode;
      end
   end

   assign bus.out  = out_q;
   assign bus.idx  = idx_q;
   assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Scoreboard bench for seq_decoder: a reference model pushes {out,idx,wrap} per edge,
// the checker pops and compares half a cycle later.
module tb_seq_decoder;

   localparam int SEL_W   = 3;
   localparam int DWELL_W = 8;

   logic clk;
   logic rst_n;

   seq_decoder_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bif ();

   seq_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // reference model
   logic [2:0]  m_idx;
   logic [7:0]  m_cnt;
   logic [7:0]  m_out;
   logic        m_wrap;
   logic        m_mq;
   logic [11:0] sb[$];

   always @(posedge clk or negedge rst_n) begin
      logic [2:0] nidx;
      logic       nw;
      if (!rst_n) begin
         m_idx = '0; m_cnt = '0; m_out = '0; m_wrap = 1'b0; m_mq = 1'b0;
         sb.delete();
      end else begin
         nidx = m_idx;
         nw   = 1'b0;
         if (bif.load) begin
            nidx  = bif.sel;
            m_cnt = '0;
         end else if (bif.mode && !m_mq) begin
            m_cnt = '0;
         end else if (bif.mode && bif.step_en) begin
            if (m_cnt == bif.dwell) begin
               m_cnt = '0;
               nidx  = m_idx + 3'd1;
               nw    = (m_idx == 3'd7);
            end else begin
               m_cnt = m_cnt + 8'd1;
            end
         end else if (!bif.mode) begin
            m_cnt = '0;
         end
         m_out  = bif.oe ? (8'd1 << nidx) : 8'd0;
         m_idx  = nidx;
         m_wrap = nw;
         m_mq   = bif.mode;
         sb.push_back({m_out, m_idx, m_wrap});
      end
   end

   always @(negedge clk) begin
      logic [11:0] e;
      if (rst_n && sb.size() > 0) begin
         e = sb.pop_front();
         chk("cyc", {52'd0, bif.out, bif.idx, bif.wrap}, {52'd0, e});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_for(input logic [2:0] want, input bit need_hit, input string tag);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (m_idx == want && (!need_hit || m_cnt == bif.dwell)) ok = 1'b1;
      end
      chk(tag, {61'd0, bif.idx}, {61'd0, want});
   endtask

   initial begin
      int wraps;
      rst_n       = 1'b0;
      bif.oe      = 1'b1;
      bif.mode    = 1'b0;
      bif.load    = 1'b0;
      bif.sel     = '0;
      bif.step_en = 1'b0;
      bif.dwell   = '0;
      #23;
      chk("rst_out",  {56'd0, bif.out}, 64'd0);
      chk("rst_idx",  {61'd0, bif.idx}, 64'd0);
      chk("rst_wrap", {63'd0, bif.wrap}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      @(negedge clk);
      bif.load = 1'b1; bif.sel = 3'd5;
      @(negedge clk);
      bif.load = 1'b0;
      chk("ld5_out", {56'd0, bif.out}, 64'h20);
      chk("ld5_idx", {61'd0, bif.idx}, 64'd5);

      // direct sweep, outputs enabled then blanked
      for (int pass = 0; pass < 2; pass++) begin
         bif.oe = (pass == 0);
         for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            bif.load = 1'b1; bif.sel = 3'(s);
            @(negedge clk);
            bif.load = 1'b0;
            chk("dir_out", {56'd0, bif.out}, (pass == 0) ? (64'd1 << s) : 64'd0);
            chk("dir_idx", {61'd0, bif.idx}, 64'(s));
            repeat (8) @(negedge clk);
         end
      end

      // scan, dwell=2, from idx 0
      bif.oe = 1'b1; bif.dwell = 8'd2; bif.step_en = 1'b1;
      @(negedge clk);
      bif.load = 1'b1; bif.sel = 3'd0;
      @(negedge clk);
      bif.load = 1'b0; bif.mode = 1'b1;
      @(negedge clk);
      wraps = 0;
      repeat (48) begin
         @(negedge clk);
         wraps += int'(bif.wrap);
      end
      chk("wrap_cnt", 64'(wraps), 64'd2);

      // dwell=0, step_en toggling
      bif.dwell = 8'd0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         bif.step_en = i[0];
      end

      // load collides with advance at idx 7
      bif.dwell = 8'd2; bif.step_en = 1'b1;
      wait_for(3'd7, 1'b1, "reach7");
      bif.load = 1'b1; bif.sel = 3'd3;
      @(negedge clk);
      bif.load = 1'b0;
      chk("col_idx",  {61'd0, bif.idx}, 64'd3);
      chk("col_wrap", {63'd0, bif.wrap}, 64'd0);
      chk("col_out",  {56'd0, bif.out}, 64'h08);
      repeat (10) @(negedge clk);

      // asynchronous reset mid-scan
      wait_for(3'd4, 1'b0, "reach4");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out",  {56'd0, bif.out}, 64'd0);
      chk("arst_idx",  {61'd0, bif.idx}, 64'd0);
      chk("arst_wrap", {63'd0, bif.wrap}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_hold", {61'd0, bif.idx}, 64'd0);
      end
      @(negedge clk);
      chk("post_adv", {61'd0, bif.idx}, 64'd1);
      repeat (30) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
